// File: rtl/axi_io_bridge_pkg.sv
// Shared types and constants for the AXI4-to-simple-I/O bridge.
package axi_io_bridge_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE,
    STATE_WRITE_BURST,
    STATE_WRITE_RESP,
    STATE_READ_ISSUE,
    STATE_READ_WAIT,
    STATE_READ_DATA
  } io_bridge_state_t;

  localparam logic [31:0] IO_DECODE_ERROR_DATA = 32'hdeadbeef;
  localparam logic [31:0] IO_BEAT_BYTES        = 32'd4;

  // INCR bursts of 4-byte beats; the add wraps naturally at 2^32.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr);
    return addr + IO_BEAT_BYTES;
  endfunction

endpackage

// File: rtl/axi_io_bridge_if.sv
// AXI4 subset shared by the interconnect and its slaves; m_* driven by the master, s_* by the slave.
interface axi4_interface;
  logic        m_awvalid;
  logic [31:0] m_awadr;
  logic [7:0]  m_awlen;
  logic        s_awready;
  logic        m_wvalid;
  logic [31:0] m_wdata;
  logic        m_wlast;
  logic        s_wready;
  logic        s_bvalid;
  logic        m_bready;
  logic        m_arvalid;
  logic [31:0] m_aradr;
  logic [7:0]  m_arlen;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        m_rready;

  modport master (
    output m_awvalid, m_awadr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
           m_arvalid, m_aradr, m_arlen, m_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );

  modport slave (
    input  m_awvalid, m_awadr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
           m_arvalid, m_aradr, m_arlen, m_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi_io_bridge.sv
// AXI4 slave turning INCR bursts into single-word I/O strobes, one transaction at a time.
// Optional out-of-range beat suppression and sticky decode_error under AXI_IO_BRIDGE_ADDR_CHECK_EN.
module axi_io_bridge
  import axi_io_bridge_pkg::*;
#(
  parameter int IO_ADDR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  axi4_interface.slave             axi_bus,
  output logic                     io_read_en,
  output logic                     io_write_en,
  output logic [IO_ADDR_WIDTH-1:0] io_address,
  output logic [31:0]              io_write_data,
  input  logic [31:0]              io_read_data,
  output logic                     decode_error
);

  io_bridge_state_t state_q;
  logic [31:0]      burst_addr_q;
  logic [7:0]       burst_count_q;
  logic [31:0]      read_data_q;
  logic             decode_error_q;

  logic [31:0] burst_addr_d;
  logic [7:0]  burst_count_d;
  logic        addr_ok;
  logic        wr_beat;
  logic        err_beat;
  logic        unused_wlast;

`ifdef AXI_IO_BRIDGE_ADDR_CHECK_EN
  assign addr_ok = (burst_addr_q >> IO_ADDR_WIDTH) == 32'd0;
`else
  assign addr_ok = 1'b1;
`endif

  // The beat counter alone ends a write burst, so WLAST is not consulted.
  assign unused_wlast = axi_bus.m_wlast;

  assign burst_addr_d  = next_beat_addr(burst_addr_q);
  assign burst_count_d = burst_count_q - 8'd1;
  assign wr_beat       = (state_q == STATE_WRITE_BURST) && axi_bus.m_wvalid;
  assign err_beat      = !addr_ok && (wr_beat || (state_q == STATE_READ_ISSUE));

  assign axi_bus.s_awready = (state_q == STATE_IDLE);
  assign axi_bus.s_arready = (state_q == STATE_IDLE) && !axi_bus.m_awvalid;
  assign axi_bus.s_wready  = (state_q == STATE_WRITE_BURST);
  assign axi_bus.s_bvalid  = (state_q == STATE_WRITE_RESP);
  assign axi_bus.s_rvalid  = (state_q == STATE_READ_DATA);
  assign axi_bus.s_rdata   = read_data_q;

  assign io_write_en   = wr_beat && addr_ok;
  assign io_read_en    = (state_q == STATE_READ_ISSUE) && addr_ok;
  assign io_address    = burst_addr_q[IO_ADDR_WIDTH-1:0];
  assign io_write_data = axi_bus.m_wdata;
  assign decode_error  = decode_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= STATE_IDLE;
      burst_addr_q   <= '0;
      burst_count_q  <= '0;
      read_data_q    <= '0;
      decode_error_q <= 1'b0;
    end else begin
      if (err_beat) decode_error_q <= 1'b1;
      case (state_q)
        STATE_IDLE: begin
          if (axi_bus.m_awvalid) begin
            burst_addr_q  <= axi_bus.m_awadr;
            burst_count_q <= axi_bus.m_awlen;
            state_q       <= STATE_WRITE_BURST;
          end else if (axi_bus.m_arvalid) begin
            burst_addr_q  <= axi_bus.m_aradr;
            burst_count_q <= axi_bus.m_arlen;
            state_q       <= STATE_READ_ISSUE;
          end
        end
        STATE_WRITE_BURST: begin
          if (axi_bus.m_wvalid) begin
            burst_addr_q  <= burst_addr_d;
            burst_count_q <= burst_count_d;
            if (burst_count_q == 8'd0) state_q <= STATE_WRITE_RESP;
          end
        end
        STATE_WRITE_RESP: begin
          if (axi_bus.m_bready) state_q <= STATE_IDLE;
        end
        STATE_READ_ISSUE: state_q <= STATE_READ_WAIT;
        STATE_READ_WAIT: begin
          // io_read_data is valid exactly one cycle after the strobe.
          read_data_q <= addr_ok ? io_read_data : IO_DECODE_ERROR_DATA;
          state_q     <= STATE_READ_DATA;
        end
        STATE_READ_DATA: begin
          if (axi_bus.m_rready) begin
            if (burst_count_q == 8'd0) begin
              state_q <= STATE_IDLE;
            end else begin
              burst_addr_q  <= burst_addr_d;
              burst_count_q <= burst_count_d;
              state_q       <= STATE_READ_ISSUE;
            end
          end
        end
        default: state_q <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_io_bridge.sv
// Randomized bench for axi_io_bridge against a burst-level reference model and a simple peripheral memory.
module tb_axi_io_bridge;

  localparam int AW = 16;
`ifdef AXI_IO_BRIDGE_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_interface axi_bus ();
  logic          io_read_en, io_write_en, decode_error;
  logic [AW-1:0] io_address;
  logic [31:0]   io_write_data, io_read_data;

  axi_io_bridge #(.IO_ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .axi_bus      (axi_bus),
    .io_read_en   (io_read_en),
    .io_write_en  (io_write_en),
    .io_address   (io_address),
    .io_write_data(io_write_data),
    .io_read_data (io_read_data),
    .decode_error (decode_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    return 32'(idx) << 2;
  endfunction

  // Peripheral: 1024-word RAM aliased over the I/O space, read data one cycle after the strobe.
  logic [31:0] periph_mem [1024];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) periph_mem[i] <= init_word(i);
    end else if (io_write_en) begin
      periph_mem[io_address[11:2]] <= io_write_data;
    end
    if (io_read_en) io_read_data <= periph_mem[io_address[11:2]];
  end

  logic [47:0] wr_obs[$];
  int          rd_pulses = 0;
  always @(negedge clk) begin
    if (io_write_en) wr_obs.push_back({io_address, io_write_data});
    if (io_read_en) rd_pulses++;
  end

  // Reference model: word store, expected write stream, sticky error.
  logic [31:0] ref_mem [1024];
  logic [47:0] wr_exp[$];
  bit          exp_err;

  function automatic bit beat_ok(input logic [31:0] a);
    return !CHECK_EN || (a < 32'h0001_0000);
  endfunction

  task automatic aw_req(input logic [31:0] a, input logic [7:0] len);
    bit rdy = 1'b0;
    int n = 0;
    axi_bus.m_awvalid = 1'b1; axi_bus.m_awadr = a; axi_bus.m_awlen = len;
    while (!rdy && n < 50) begin
      @(negedge clk); rdy = axi_bus.s_awready; n++;
      if (!rdy) begin @(posedge clk); #1; end
    end
    check_eq("aw_accept", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    axi_bus.m_awvalid = 1'b0;
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [7:0] len);
    bit rdy = 1'b0;
    int n = 0;
    axi_bus.m_arvalid = 1'b1; axi_bus.m_aradr = a; axi_bus.m_arlen = len;
    while (!rdy && n < 50) begin
      @(negedge clk); rdy = axi_bus.s_arready; n++;
      if (!rdy) begin @(posedge clk); #1; end
    end
    check_eq("ar_accept", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    axi_bus.m_arvalid = 1'b0;
  endtask

  task automatic w_burst(input logic [31:0] a, input int len, input int max_gap, input int abort_beat);
    logic [31:0] addr;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        axi_bus.m_wvalid = 1'b0; @(posedge clk); #1;
      end
      axi_bus.m_wvalid = 1'b1; axi_bus.m_wdata = $urandom; axi_bus.m_wlast = (i == len);
      if (i == abort_beat) begin
        #2 reset = 1'b1;
        axi_bus.m_wvalid = 1'b0; axi_bus.m_wlast = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        check_eq("rst_wready", 64'(axi_bus.s_wready), 64'd0);
        check_eq("rst_bvalid", 64'(axi_bus.s_bvalid), 64'd0);
        check_eq("rst_awready", 64'(axi_bus.s_awready), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      addr = a + 32'(4 * i);
      if (beat_ok(addr)) begin
        wr_exp.push_back({addr[15:0], axi_bus.m_wdata});
        ref_mem[addr[11:2]] = axi_bus.m_wdata;
      end else begin
        exp_err = 1'b1;
      end
      @(negedge clk);
      if (i == 0) check_eq("w_ready", 64'(axi_bus.s_wready), 64'd1);
      @(posedge clk); #1;
    end
    axi_bus.m_wvalid = 1'b0; axi_bus.m_wlast = 1'b0;
    @(negedge clk);
    check_eq("b_latency", 64'(axi_bus.s_bvalid), 64'd1);
    @(posedge clk); #1;
    axi_bus.m_bready = 1'b1;
    @(posedge clk); #1;
    axi_bus.m_bready = 1'b0;
    @(negedge clk);
    check_eq("w_idle", 64'(axi_bus.s_awready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_count"}, 64'(wr_obs.size()), 64'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_obs.size(); i++)
      check_eq(tag, 64'(wr_obs[i]), 64'(wr_exp[i]));
    wr_obs.delete();
    wr_exp.delete();
  endtask

  task automatic r_burst(input logic [31:0] a, input int len, input int stall_beat, input int stall_cycles);
    int          base = rd_pulses;
    int          n_ok = 0;
    int          n, p0;
    bit          got, stable;
    logic [31:0] addr, exp;
    for (int i = 0; i <= len; i++) begin
      addr = a + 32'(4 * i);
      if (beat_ok(addr)) begin
        n_ok++;
        exp = ref_mem[addr[11:2]];
      end else begin
        exp_err = 1'b1;
        exp = 32'hdeadbeef;
      end
      axi_bus.m_rready = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
        @(negedge clk); n++; got = axi_bus.s_rvalid;
        if (!got) begin @(posedge clk); #1; end
      end
      check_eq("r_latency", 64'(n), 64'd3);
      if (i == stall_beat) begin
        p0 = rd_pulses; stable = 1'b1;
        repeat (stall_cycles) begin
          @(posedge clk); #1;
          @(negedge clk);
          if (!(axi_bus.s_rvalid && axi_bus.s_rdata == exp)) stable = 1'b0;
        end
        check_eq("r_hold", 64'(stable), 64'd1);
        check_eq("r_no_extra_strobe", 64'(rd_pulses), 64'(p0));
      end
      axi_bus.m_rready = 1'b1;
      check_eq("r_data", 64'(axi_bus.s_rdata), 64'(exp));
      @(posedge clk); #1;
      axi_bus.m_rready = 1'b0;
    end
    @(negedge clk);
    check_eq("r_strobes", 64'(rd_pulses - base), 64'(n_ok));
    check_eq("r_idle", 64'(axi_bus.s_arready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    int          len;
    reset = 1'b1; mem_init = 1'b1; exp_err = 1'b0;
    axi_bus.m_awvalid = 1'b0; axi_bus.m_awadr = '0; axi_bus.m_awlen = '0;
    axi_bus.m_wvalid = 1'b0; axi_bus.m_wdata = '0; axi_bus.m_wlast = 1'b0;
    axi_bus.m_bready = 1'b0; axi_bus.m_arvalid = 1'b0; axi_bus.m_aradr = '0;
    axi_bus.m_arlen = '0; axi_bus.m_rready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    @(negedge clk);
    check_eq("rst_awready", 64'(axi_bus.s_awready), 64'd1);
    check_eq("rst_arready", 64'(axi_bus.s_arready), 64'd1);
    check_eq("rst_wready", 64'(axi_bus.s_wready), 64'd0);
    check_eq("rst_bvalid", 64'(axi_bus.s_bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(axi_bus.s_rvalid), 64'd0);
    check_eq("rst_rd_en", 64'(io_read_en), 64'd0);
    check_eq("rst_wr_en", 64'(io_write_en), 64'd0);
    check_eq("rst_decode_error", 64'(decode_error), 64'd0);
    axi_bus.m_awvalid = 1'b1;
    #1 check_eq("rst_arready_blocked", 64'(axi_bus.s_arready), 64'd0);
    axi_bus.m_awvalid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Single write, then a 4-beat read of untouched locations.
    aw_req(32'h10, 8'd0);
    w_burst(32'h10, 0, 0, -1);
    compare_writes("single_write");
    ar_req(32'h100, 8'd3);
    r_burst(32'h100, 3, -1, 0);

    // Backpressure on reads and gappy write data.
    ar_req(32'h200, 8'd3);
    r_burst(32'h200, 3, 1, 5);
    aw_req(32'h300, 8'd5);
    w_burst(32'h300, 5, 3, -1);
    compare_writes("gappy_write");
    ar_req(32'h300, 8'd5);
    r_burst(32'h300, 5, -1, 0);

    // Simultaneous AW/AR: write wins, read follows the B handshake.
    axi_bus.m_awvalid = 1'b1; axi_bus.m_awadr = 32'h400; axi_bus.m_awlen = 8'd1;
    axi_bus.m_arvalid = 1'b1; axi_bus.m_aradr = 32'h400; axi_bus.m_arlen = 8'd1;
    @(negedge clk);
    check_eq("arb_awready", 64'(axi_bus.s_awready), 64'd1);
    check_eq("arb_arready", 64'(axi_bus.s_arready), 64'd0);
    @(posedge clk); #1 axi_bus.m_awvalid = 1'b0;
    @(negedge clk);
    check_eq("arb_arready_busy", 64'(axi_bus.s_arready), 64'd0);
    @(posedge clk); #1;
    w_burst(32'h400, 1, 1, -1);
    axi_bus.m_arvalid = 1'b0;
    r_burst(32'h400, 1, -1, 0);
    compare_writes("arb_write");

    // Reset during the third beat of an 8-beat write, then a clean write.
    aw_req(32'h500, 8'd7);
    w_burst(32'h500, 7, 0, 2);
    compare_writes("aborted_write");
    aw_req(32'h600, 8'd2);
    w_burst(32'h600, 2, 1, -1);
    compare_writes("post_reset_write");
    ar_req(32'h500, 8'd2);
    r_burst(32'h500, 2, -1, 0);

    // Maximum-length bursts.
    aw_req(32'hFC00, 8'd255);
    w_burst(32'hFC00, 255, 0, -1);
    compare_writes("len255_write");
    ar_req(32'hFC00, 8'd255);
    r_burst(32'hFC00, 255, 100, 2);

    // 2^32 wrap and the first address beyond the I/O window.
    ar_req(32'hFFFF_FFF8, 8'd3);
    r_burst(32'hFFFF_FFF8, 3, -1, 0);
    ar_req(32'h0001_0000, 8'd0);
    r_burst(32'h0001_0000, 0, 0, 2);
    check_eq("decode_error_window", 64'(decode_error), 64'(exp_err));
    aw_req(32'h0000_FFF8, 8'd3);
    w_burst(32'h0000_FFF8, 3, 0, -1);
    compare_writes("window_edge_write");

    for (int t = 0; t < 30; t++) begin
      a   = ($urandom_range(0, 3) == 0) ? 32'h0000_FFF0 : 32'($urandom_range(0, 1023)) << 2;
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        aw_req(a, 8'(len));
        w_burst(a, len, 2, -1);
        compare_writes("rand_write");
      end else begin
        ar_req(a, 8'(len));
        r_burst(a, len, $urandom_range(0, 7), $urandom_range(1, 4));
      end
    end
    check_eq("decode_error_final", 64'(decode_error), 64'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
